// File: rtl/vending_pkg.sv
// Shared vending-machine types.
//   state_t      : change_dispenser FSM states
//   coin_t       : which ejector a payout step selected
//   NICKEL_CENTS : value of one amount unit, in cents
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_NICKEL,
    COIN_DIME
  } coin_t;

  localparam int NICKEL_CENTS = 5;

endpackage

// File: rtl/change_dispenser_if.sv
// Controller <-> change dispenser bundle.
//   req_valid/req_amount/req_ready : change request (amount in nickels)
//   load_nickels/load_dimes/load_count : inventory refill strobes
//   nickel_eject/dime_eject        : solenoid drives
//   done/shortfall                 : completion pulse, unpaid nickels
//   nickel_inv/dime_inv            : current inventories
// master = vending controller side, slave = dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 6,
  parameter int INV_W = 8
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             load_nickels;
  logic             load_dimes;
  logic [INV_W-1:0] load_count;
  logic             nickel_eject;
  logic             dime_eject;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic [INV_W-1:0] nickel_inv;
  logic [INV_W-1:0] dime_inv;

  modport master (
    output req_valid, req_amount, load_nickels, load_dimes, load_count,
    input  req_ready, nickel_eject, dime_eject, done, shortfall,
           nickel_inv, dime_inv
  );

  modport slave (
    input  req_valid, req_amount, load_nickels, load_dimes, load_count,
    output req_ready, nickel_eject, dime_eject, done, shortfall,
           nickel_inv, dime_inv
  );
endinterface

// File: rtl/eject_timer.sv
// Ejector pulse/gap timer. A start strobe loads the pulse phase
// (PULSE_LEN cycles); its last cycle raises pulse_done and the counter
// reloads itself for the gap phase (GAP_LEN cycles), whose last cycle
// raises gap_done.
//   clock, reset : sync active-high reset
//   start        : begin a pulse phase next cycle
//   pulse_done   : last cycle of the pulse phase
//   gap_done     : last cycle of the gap phase
module eject_timer #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic pulse_done,
  output logic gap_done
);
  localparam int MAXL = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {PH_IDLE, PH_PULSE, PH_GAP} phase_t;

  phase_t        phase;
  logic [CW-1:0] cnt;

  assign pulse_done = (phase == PH_PULSE) && (cnt == '0);
  assign gap_done   = (phase == PH_GAP)   && (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= PH_IDLE;
      cnt   <= '0;
    end else if (start) begin
      phase <= PH_PULSE;
      cnt   <= CW'(PULSE_LEN - 1);
    end else if (pulse_done) begin
      phase <= PH_GAP;
      cnt   <= CW'(GAP_LEN - 1);
    end else if (gap_done) begin
      phase <= PH_IDLE;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/change_dispenser.sv
// Coin payout engine. Takes a change request in nickel units, pays it
// greedily (dimes first) one coin at a time through the ejector
// solenoids, tracks nickel/dime inventory with saturating refills and
// reports the unpaid remainder on the done pulse.
//   clock, reset : sync active-high reset
//   bus          : change_dispenser_if.slave (request, refill, ejectors,
//                  done/shortfall, inventories)
module change_dispenser #(
  parameter int AMT_W     = 6,
  parameter int INV_W     = 8,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic              clock,
  input  logic              reset,
  change_dispenser_if.slave bus
);
  import vending_pkg::*;

  state_t           state, state_nx;
  coin_t            coin, pick;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] nickel_inv, dime_inv;
  logic             pulse_done, gap_done;
  logic             dec_n, dec_d;
  logic [INV_W:0]   n_sum, d_sum;

  eject_timer #(.PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .start      (state == ST_SELECT && pick != COIN_NONE),
    .pulse_done (pulse_done),
    .gap_done   (gap_done)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Greedy choice: a dime only when at least 10c is still owed, so the
  // machine never overpays.
  always_comb begin
    state_nx = state;
    pick     = COIN_NONE;
    case (state)
      ST_IDLE:   if (bus.req_valid) state_nx = ST_SELECT;
      ST_SELECT: begin
        if (remaining >= AMT_W'(2) && dime_inv != '0) begin
          pick     = COIN_DIME;
          state_nx = ST_EJECT;
        end else if (remaining != '0 && nickel_inv != '0) begin
          pick     = COIN_NICKEL;
          state_nx = ST_EJECT;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_EJECT:  if (pulse_done) state_nx = ST_GAP;
      ST_GAP:    if (gap_done)   state_nx = ST_SELECT;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign dec_n = (state == ST_SELECT) && (pick == COIN_NICKEL);
  assign dec_d = (state == ST_SELECT) && (pick == COIN_DIME);

  // One bit of headroom catches the refill overflow. A decrement only
  // happens with a non-empty counter, so the sum cannot underflow.
  always_comb begin
    n_sum = {1'b0, nickel_inv} - {{INV_W{1'b0}}, dec_n}
          + (bus.load_nickels ? {1'b0, bus.load_count} : '0);
    d_sum = {1'b0, dime_inv} - {{INV_W{1'b0}}, dec_d}
          + (bus.load_dimes ? {1'b0, bus.load_count} : '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remaining  <= '0;
      coin       <= COIN_NONE;
      nickel_inv <= '0;
      dime_inv   <= '0;
    end else begin
      if (state == ST_IDLE && bus.req_valid) remaining <= bus.req_amount;
      if (state == ST_SELECT) begin
        coin <= pick;
        if (dec_d)      remaining <= remaining - AMT_W'(2);
        else if (dec_n) remaining <= remaining - AMT_W'(1);
      end
      nickel_inv <= n_sum[INV_W] ? '1 : n_sum[INV_W-1:0];
      dime_inv   <= d_sum[INV_W] ? '1 : d_sum[INV_W-1:0];
    end
  end

  assign bus.req_ready    = (state == ST_IDLE);
  assign bus.done         = (state == ST_DONE);
  assign bus.shortfall    = (state == ST_DONE) ? remaining : '0;
  assign bus.nickel_eject = (state == ST_EJECT) && (coin == COIN_NICKEL);
  assign bus.dime_eject   = (state == ST_EJECT) && (coin == COIN_DIME);
  assign bus.nickel_inv   = nickel_inv;
  assign bus.dime_inv     = dime_inv;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout model, expected
// results queued on request and compared when done pulses, ejector
// activity checked every cycle against the model's coin schedule.
module tb_change_dispenser;
  localparam int AMT_W = 6, INV_W = 8, PULSE_LEN = 4, GAP_LEN = 2;
  localparam int COIN_CYC = 1 + PULSE_LEN + GAP_LEN;

  typedef struct {
    int done_cyc;
    int shortfall;
    int nick;
    int dime;
    int nick1;
    int dime1;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0, bad = 0;
  int   mnick = 0, mdime = 0;
  exp_t sb[$];

  change_dispenser_if #(.AMT_W(AMT_W), .INV_W(INV_W)) bus();

  change_dispenser #(
    .AMT_W(AMT_W), .INV_W(INV_W), .PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  32'(bus.req_ready), 1);
    check({tag, "_neject"}, 32'(bus.nickel_eject), 0);
    check({tag, "_deject"}, 32'(bus.dime_eject), 0);
    check({tag, "_done"},   32'(bus.done), 0);
    check({tag, "_short"},  32'(bus.shortfall), 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; bus.req_valid = 1'b0;
    bus.load_nickels = 1'b0; bus.load_dimes = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; mnick = 0; mdime = 0;
    @(negedge clock);
    check_idle_outputs("reset");
    check("reset_ninv", 32'(bus.nickel_inv), 0);
    check("reset_dinv", 32'(bus.dime_inv), 0);
  endtask

  task automatic do_load(input bit ln, input bit ld, input int cnt);
    @(posedge clock); #1;
    bus.load_nickels = ln; bus.load_dimes = ld; bus.load_count = INV_W'(cnt);
    @(posedge clock); #1;
    bus.load_nickels = 1'b0; bus.load_dimes = 1'b0;
    if (ln) mnick = sat(mnick + cnt);
    if (ld) mdime = sat(mdime + cnt);
    @(negedge clock);
    check("load_ninv", 32'(bus.nickel_inv), 32'(mnick));
    check("load_dinv", 32'(bus.dime_inv), 32'(mdime));
  endtask

  // sel_ld: dimes refilled during the first SELECT cycle (0 = none).
  // hold:   keep req_valid high for the whole payout.
  task automatic run_req(input int amt, input int sel_ld, input bit hold);
    int   seq[$];
    int   rem, mn, md, pick, T, n, off, coin;
    bit   got, act;
    exp_t e;
    rem = amt; mn = mnick; md = mdime; got = 1'b0;
    for (int step = 0; step < 64; step++) begin
      pick = 0;
      if (rem >= 2 && md > 0) begin pick = 2; md--; rem -= 2; end
      else if (rem >= 1 && mn > 0) begin pick = 1; mn--; rem -= 1; end
      if (step == 0) begin
        md = sat(md + sel_ld);
        e.nick1 = mn; e.dime1 = md;
      end
      if (pick == 0) break;
      seq.push_back(pick);
    end
    n = seq.size();

    @(posedge clock); #1;
    T = cyc;
    bus.req_valid = 1'b1; bus.req_amount = AMT_W'(amt);
    e.done_cyc = T + 2 + COIN_CYC * n;
    e.shortfall = rem; e.nick = mn; e.dime = md;
    sb.push_back(e);
    @(negedge clock);
    check("ready_at_req", 32'(bus.req_ready), 1);

    for (int i = 0; i < COIN_CYC * n + 8 && !got; i++) begin
      @(posedge clock); #1;
      if (!hold) bus.req_valid = 1'b0;
      bus.load_dimes = (cyc == T + 1) && (sel_ld != 0);
      bus.load_count = INV_W'(sel_ld);
      @(negedge clock);
      off = cyc - T - 2;
      act = (off >= 0) && (off / COIN_CYC < n) && (off % COIN_CYC < PULSE_LEN);
      coin = act ? seq[off / COIN_CYC] : 0;
      check("dime_eject",   32'(bus.dime_eject),   32'(coin == 2));
      check("nickel_eject", 32'(bus.nickel_eject), 32'(coin == 1));
      check("ready_busy",   32'(bus.req_ready), 0);
      if (cyc == T + 2) begin
        check("first_sel_dinv", 32'(bus.dime_inv),   32'(e.dime1));
        check("first_sel_ninv", 32'(bus.nickel_inv), 32'(e.nick1));
      end
      if (bus.done === 1'b1) begin
        got = 1'b1;
        bus.req_valid = 1'b0;
        e = sb.pop_front();
        check("done_cycle", 32'(cyc - T), 32'(e.done_cyc - T));
        check("shortfall",  32'(bus.shortfall),  32'(e.shortfall));
        check("final_ninv", 32'(bus.nickel_inv), 32'(e.nick));
        check("final_dinv", 32'(bus.dime_inv),   32'(e.dime));
      end else begin
        check("shortfall_quiet", 32'(bus.shortfall), 0);
      end
    end
    check("done_seen", 32'(got), 1);
    bus.req_valid = 1'b0; bus.load_dimes = 1'b0;
    mnick = mn; mdime = md;
    repeat (2) begin
      @(negedge clock);
      check_idle_outputs("after_done");
    end
  endtask

  initial begin
    int T;
    bus.req_valid = 1'b0; bus.req_amount = '0;
    bus.load_nickels = 1'b0; bus.load_dimes = 1'b0; bus.load_count = '0;

    // 1: five of each, request 15c -> dime then nickel
    do_reset();
    do_load(1'b1, 1'b1, 5);
    run_req(3, 0, 1'b0);

    // 2: zero request
    run_req(0, 0, 1'b0);

    // 3: nickels only
    do_reset();
    do_load(1'b1, 1'b0, 10);
    run_req(4, 0, 1'b0);

    // 4: dimes only, odd amount leaves 5c unpaid
    do_reset();
    do_load(1'b0, 1'b1, 3);
    run_req(3, 0, 1'b0);

    // 5a: refill collides with the SELECT decrement
    do_reset();
    do_load(1'b0, 1'b1, 1);
    run_req(2, 2, 1'b0);

    // 5b: req_valid held through the payout is not re-accepted
    do_load(1'b1, 1'b0, 10);
    run_req(5, 0, 1'b1);

    // 5c: refill saturation
    do_reset();
    do_load(1'b1, 1'b1, 10);
    do_load(1'b1, 1'b1, 250);

    // 6: reset in the middle of an ejector pulse
    do_reset();
    do_load(1'b0, 1'b1, 2);
    @(posedge clock); #1;
    T = cyc;
    bus.req_valid = 1'b1; bus.req_amount = AMT_W'(2);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("pre_reset_deject", 32'(bus.dime_eject), 1);
    check("pre_reset_cycle",  32'(cyc - T), 2);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("mid_reset");
    check("mid_reset_ninv", 32'(bus.nickel_inv), 0);
    check("mid_reset_dinv", 32'(bus.dime_inv), 0);
    repeat (12) begin
      @(negedge clock);
      check_idle_outputs("post_reset");
    end

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
